// File: rtl/pe_row_accumulator_if.sv
// Row-product bus between the PE array and the row accumulator.
// Bundles the job control, the product beat handshake and the
// result handshake toward the psum buffer.
interface pe_row_accumulator_if #(
   parameter int DataWidth = 8,
   parameter int NumPE     = 11,
   parameter int AccWidth  = 32
);
   logic                                 start;
   logic [7:0]                           acc_len;
   logic [NumPE-1:0]                     lane_mask;
   logic                                 p_valid;
   logic                                 p_ready;
   logic [NumPE-1:0][2*DataWidth-1:0]    Bus_P;
   logic                                 out_valid;
   logic                                 out_ready;
   logic [AccWidth-1:0]                  out_sum;
   logic                                 out_ovf;
   logic                                 busy;

   // Upstream side: job control, the PE products and the result sink
   modport master (
      output start, acc_len, lane_mask, p_valid, Bus_P, out_ready,
      input  p_ready, out_valid, out_sum, out_ovf, busy
   );

   // Accumulator side
   modport slave (
      input  start, acc_len, lane_mask, p_valid, Bus_P, out_ready,
      output p_ready, out_valid, out_sum, out_ovf, busy
   );
endinterface

// File: rtl/pe_row_accumulator.sv
// Row accumulator sitting directly below the PE array.
// Each accepted beat masks the enabled lanes, reduces the NumPE products
// with an adder tree and adds the tree sum into an accumulator. After the
// programmed number of beats the row partial sum is offered on a
// valid/ready port toward the psum buffer. The lane mask lets one array
// serve 3/5/7/11-wide kernels. AccWidth must be at least
// 2*DataWidth+$clog2(NumPE) so a single tree sum always fits.
module pe_row_accumulator #(
   parameter int DataWidth = 8,
   parameter int NumPE     = 11,
   parameter int AccWidth  = 32
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   pe_row_accumulator_if.slave        rowIf
);

   localparam int TreeWidth = 2*DataWidth + $clog2(NumPE);
   localparam int SumWidth  = AccWidth + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [AccWidth-1:0]  acc_q, acc_d;
   logic [7:0]           count_q, count_d;
   logic [7:0]           len_q, len_d;
   logic [NumPE-1:0]     mask_q, mask_d;
   logic [AccWidth-1:0]  sum_q, sum_d;
   logic                 valid_q, valid_d;
   logic                 ovf_q, ovf_d;

   logic [TreeWidth-1:0] treeSum;
   logic [SumWidth-1:0]  sumWide;
   logic                 beat;

   // Masked adder tree over the lanes plus the carry-extended accumulate
   always_comb begin
      treeSum = '0;
      for (int i = 0; i < NumPE; i++) begin
         if (mask_q[i]) begin
            treeSum = treeSum + TreeWidth'(rowIf.Bus_P[i]);
         end
      end
      sumWide = {1'b0, acc_q} + SumWidth'(treeSum);
   end

   assign beat = rowIf.p_valid && (state_q == ACC);

   // Next-state logic: job start, beat accumulation and result handshake
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      count_d = count_q;
      len_d   = len_q;
      mask_d  = mask_q;
      sum_d   = sum_q;
      valid_d = valid_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (rowIf.start) begin
               len_d   = (rowIf.acc_len == 8'd0) ? 8'd1 : rowIf.acc_len;
               mask_d  = rowIf.lane_mask;
               acc_d   = '0;
               count_d = '0;
               ovf_d   = 1'b0;
               state_d = ACC;
            end
         end
         ACC: begin
            if (beat) begin
               acc_d   = sumWide[AccWidth-1:0];
               count_d = count_q + 8'd1;
               if (sumWide[AccWidth]) begin
                  ovf_d = 1'b1;
               end
               if ((count_q + 8'd1) == len_q) begin
                  sum_d   = sumWide[AccWidth-1:0];
                  valid_d = 1'b1;
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (rowIf.out_ready) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any partial job
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         acc_q   <= '0;
         count_q <= '0;
         len_q   <= '0;
         mask_q  <= '0;
         sum_q   <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         count_q <= count_d;
         len_q   <= len_d;
         mask_q  <= mask_d;
         sum_q   <= sum_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
      end
   end

   assign rowIf.p_ready   = (state_q == ACC);
   assign rowIf.busy      = (state_q != IDLE);
   assign rowIf.out_valid = valid_q;
   assign rowIf.out_sum   = sum_q;
   assign rowIf.out_ovf   = ovf_q;

endmodule

// File: tb/tb_pe_row_accumulator.sv
// Directed bench for pe_row_accumulator. A 32-bit accumulator instance
// carries most scenarios; a 20-bit instance exercises wrap and overflow.
module tb_pe_row_accumulator;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   nCompared   = 0;
   int   nMismatched = 0;

   pe_row_accumulator_if #(.DataWidth(8), .NumPE(11), .AccWidth(32)) ifA ();
   pe_row_accumulator_if #(.DataWidth(8), .NumPE(11), .AccWidth(20)) ifB ();

   pe_row_accumulator #(.DataWidth(8), .NumPE(11), .AccWidth(32)) dutA (
      .clk_i (clk),
      .rst_i (rst),
      .rowIf (ifA.slave)
   );

   pe_row_accumulator #(.DataWidth(8), .NumPE(11), .AccWidth(20)) dutB (
      .clk_i (clk),
      .rst_i (rst),
      .rowIf (ifB.slave)
   );

   // 100 MHz free-running clock
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      nCompared++;
      assert (observed === expected) else begin
         nMismatched++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic setBusA(input logic [15:0] value);
      for (int i = 0; i < 11; i++) ifA.Bus_P[i] = value;
   endtask

   task automatic setBusB(input logic [15:0] value);
      for (int i = 0; i < 11; i++) ifB.Bus_P[i] = value;
   endtask

   task automatic startJobA(input logic [7:0] len, input logic [10:0] mask);
      ifA.start     = 1'b1;
      ifA.acc_len   = len;
      ifA.lane_mask = mask;
      tick();
      ifA.start     = 1'b0;
   endtask

   // One product beat on instance A with every lane carrying value
   task automatic applyStimulus(input logic [15:0] value);
      setBusA(value);
      ifA.p_valid = 1'b1;
      tick();
      ifA.p_valid = 1'b0;
   endtask

   task automatic handshakeA();
      ifA.out_ready = 1'b1;
      tick();
      ifA.out_ready = 1'b0;
   endtask

   initial begin
      ifA.start = 1'b0; ifA.acc_len = 8'd0; ifA.lane_mask = '0;
      ifA.p_valid = 1'b0; ifA.out_ready = 1'b0; setBusA(16'd0);
      ifB.start = 1'b0; ifB.acc_len = 8'd0; ifB.lane_mask = '0;
      ifB.p_valid = 1'b0; ifB.out_ready = 1'b0; setBusB(16'd0);

      // Reset state
      tick(); tick();
      rst = 1'b0;
      tick();
      checkOutput("rst_busy",    32'(ifA.busy),      32'd0);
      checkOutput("rst_valid",   32'(ifA.out_valid), 32'd0);
      checkOutput("rst_pready",  32'(ifA.p_ready),   32'd0);
      checkOutput("rst_sum",     ifA.out_sum,        32'd0);
      checkOutput("rst_ovf",     32'(ifA.out_ovf),   32'd0);

      // 1: single beat, all lanes = 1
      startJobA(8'd1, 11'h7FF);
      checkOutput("t1_busy",   32'(ifA.busy),    32'd1);
      checkOutput("t1_pready", 32'(ifA.p_ready), 32'd1);
      applyStimulus(16'd1);
      checkOutput("t1_valid",  32'(ifA.out_valid), 32'd1);
      checkOutput("t1_sum",    ifA.out_sum,        32'd11);
      checkOutput("t1_ovf",    32'(ifA.out_ovf),   32'd0);
      checkOutput("t1_hold_pready", 32'(ifA.p_ready), 32'd0);
      handshakeA();
      checkOutput("t1_idle_busy",  32'(ifA.busy),      32'd0);
      checkOutput("t1_idle_valid", 32'(ifA.out_valid), 32'd0);

      // 2: three beats on lanes 0..2 with idle gaps
      startJobA(8'd3, 11'h007);
      applyStimulus(16'd100);
      tick();
      tick();
      checkOutput("t2_gap_pready", 32'(ifA.p_ready),   32'd1);
      checkOutput("t2_gap_valid",  32'(ifA.out_valid), 32'd0);
      applyStimulus(16'd100);
      tick();
      checkOutput("t2_mid_valid",  32'(ifA.out_valid), 32'd0);
      applyStimulus(16'd100);
      checkOutput("t2_valid", 32'(ifA.out_valid), 32'd1);
      checkOutput("t2_sum",   ifA.out_sum,        32'd900);

      // 3: result held while out_ready stays low; beats are dropped
      setBusA(16'd5);
      ifA.p_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         checkOutput($sformatf("t3_hold_sum%0d", k),    ifA.out_sum,        32'd900);
         checkOutput($sformatf("t3_hold_valid%0d", k),  32'(ifA.out_valid), 32'd1);
         checkOutput($sformatf("t3_hold_pready%0d", k), 32'(ifA.p_ready),   32'd0);
      end
      ifA.p_valid = 1'b0;
      // start coinciding with the handshake must be ignored
      ifA.start = 1'b1; ifA.acc_len = 8'd1; ifA.lane_mask = 11'h7FF;
      handshakeA();
      ifA.start = 1'b0;
      checkOutput("t3_idle_busy",  32'(ifA.busy),      32'd0);
      checkOutput("t3_idle_valid", 32'(ifA.out_valid), 32'd0);
      tick();
      checkOutput("t3_start_ignored", 32'(ifA.busy), 32'd0);

      // 4: 20-bit accumulator wraps and flags overflow
      ifB.start = 1'b1; ifB.acc_len = 8'd2; ifB.lane_mask = 11'h7FF;
      tick();
      ifB.start = 1'b0;
      setBusB(16'hFFFF);
      ifB.p_valid = 1'b1;
      tick();
      checkOutput("t4_first_valid", 32'(ifB.out_valid), 32'd0);
      checkOutput("t4_first_ovf",   32'(ifB.out_ovf),   32'd0);
      tick();
      ifB.p_valid = 1'b0;
      checkOutput("t4_valid", 32'(ifB.out_valid), 32'd1);
      checkOutput("t4_sum",   32'(ifB.out_sum),   32'd393194);
      checkOutput("t4_ovf",   32'(ifB.out_ovf),   32'd1);
      ifB.out_ready = 1'b1;
      tick();
      ifB.out_ready = 1'b0;
      checkOutput("t4_ovf_sticky", 32'(ifB.out_ovf), 32'd1);
      ifB.start = 1'b1; ifB.acc_len = 8'd1;
      tick();
      ifB.start = 1'b0;
      checkOutput("t4_ovf_cleared", 32'(ifB.out_ovf), 32'd0);

      // 5: reset mid-job discards the partial sum
      startJobA(8'd4, 11'h7FF);
      applyStimulus(16'd3);
      applyStimulus(16'd3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("t5_busy",   32'(ifA.busy),      32'd0);
      checkOutput("t5_valid",  32'(ifA.out_valid), 32'd0);
      checkOutput("t5_pready", 32'(ifA.p_ready),   32'd0);
      checkOutput("t5_b_busy", 32'(ifB.busy),      32'd0);
      startJobA(8'd1, 11'h7FF);
      applyStimulus(16'd2);
      checkOutput("t5_valid_new", 32'(ifA.out_valid), 32'd1);
      checkOutput("t5_sum",       ifA.out_sum,        32'd22);
      handshakeA();

      // 6a: acc_len=0 behaves as a single beat
      startJobA(8'd0, 11'h001);
      applyStimulus(16'd7);
      checkOutput("t6_len0_valid", 32'(ifA.out_valid), 32'd1);
      checkOutput("t6_len0_sum",   ifA.out_sum,        32'd7);
      handshakeA();

      // 6b: start pulse during ACC has no effect
      startJobA(8'd2, 11'h003);
      applyStimulus(16'd10);
      ifA.start = 1'b1; ifA.acc_len = 8'd5; ifA.lane_mask = 11'h7FF;
      tick();
      ifA.start = 1'b0;
      checkOutput("t6_start_valid", 32'(ifA.out_valid), 32'd0);
      applyStimulus(16'd10);
      checkOutput("t6_start_done", 32'(ifA.out_valid), 32'd1);
      checkOutput("t6_start_sum",  ifA.out_sum,        32'd40);
      handshakeA();

      // 6c: empty lane mask yields zero
      startJobA(8'd2, 11'h000);
      applyStimulus(16'd50);
      applyStimulus(16'd50);
      checkOutput("t6_mask0_valid", 32'(ifA.out_valid), 32'd1);
      checkOutput("t6_mask0_sum",   ifA.out_sum,        32'd0);
      handshakeA();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
